// File: rtl/uart_pkg.sv
// uart_pkg: state naming and oversampling constants shared by the UART transmitter and receiver.
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
endpackage

// File: rtl/uart_tx_os_if.sv
// uart_tx_os_if: request/serial-line bundle between a UART transmitter and its user.
interface uart_tx_os_if #(parameter int DBIT = 8);
  logic s_tick;
  logic tx_start;
  logic [DBIT-1:0] din;
  logic tx_busy;
  logic tx_done_tick;
  logic tx;
  modport master(output s_tick, tx_start, din, input tx_busy, tx_done_tick, tx);
  modport slave(input s_tick, tx_start, din, output tx_busy, tx_done_tick, tx);
endinterface

// File: rtl/uart_tx_os.sv
// uart_tx_os: 16x-oversampled UART transmitter (start, DBIT data LSB first, stop).
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_os
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input logic        clk,
  input logic        reset_n,
  uart_tx_os_if.slave bus
);
  localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DBIT);
`ifdef UART_TX_PARITY_EN
  localparam uart_tx_state_t AFTER_DATA = PARITY;
`else
  localparam uart_tx_state_t AFTER_DATA = STOP;
`endif
  uart_tx_state_t state, state_n;
  logic [SW-1:0] s_cnt, s_n;
  logic [NW-1:0] n_cnt, n_n;
  logic [DBIT-1:0] b_reg, b_n;
  logic tx_reg, tx_n;
  logic bit_end, stop_end;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state  <= IDLE;
      s_cnt  <= '0;
      n_cnt  <= '0;
      b_reg  <= '0;
      tx_reg <= 1'b1;
    end else begin
      state  <= state_n;
      s_cnt  <= s_n;
      n_cnt  <= n_cnt == n_n ? n_cnt : n_n;
      b_reg  <= b_n;
      tx_reg <= tx_n;
    end
`ifdef UART_TX_PARITY_EN
  logic p_reg, p_n;
  assign p_n = (state == IDLE && bus.tx_start) ? ^bus.din : p_reg;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) p_reg <= 1'b0;
    else p_reg <= p_n;
`endif
  always_comb begin
    bit_end  = bus.s_tick && s_cnt == SW'(OVERSAMPLE - 1);
    stop_end = bus.s_tick && s_cnt == SW'(SB_TICK - 1);
    state_n  = state;
    s_n      = s_cnt;
    n_n      = n_cnt;
    b_n      = b_reg;
    case (state)
      IDLE:
        if (bus.tx_start) begin
          state_n = START;
          s_n     = '0;
          b_n     = bus.din;
        end
      START:
        if (bit_end) begin
          state_n = DATA;
          s_n     = '0;
          n_n     = '0;
        end else if (bus.s_tick) s_n = s_cnt + 1'b1;
      DATA:
        if (bit_end) begin
          s_n     = '0;
          b_n     = b_reg >> 1;
          state_n = n_cnt == NW'(DBIT - 1) ? AFTER_DATA : DATA;
          n_n     = n_cnt == NW'(DBIT - 1) ? n_cnt : n_cnt + 1'b1;
        end else if (bus.s_tick) s_n = s_cnt + 1'b1;
`ifdef UART_TX_PARITY_EN
      PARITY:
        if (bit_end) begin
          state_n = STOP;
          s_n     = '0;
        end else if (bus.s_tick) s_n = s_cnt + 1'b1;
`endif
      STOP:
        if (stop_end) begin
          state_n = IDLE;
          s_n     = '0;
        end else if (bus.s_tick) s_n = s_cnt + 1'b1;
      default: state_n = IDLE;
    endcase
    // tx is registered from the next state so each bit starts on the edge that enters it
`ifdef UART_TX_PARITY_EN
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? b_n[0] : state_n == PARITY ? p_n : 1'b1;
`else
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? b_n[0] : 1'b1;
`endif
  end
  assign bus.tx           = tx_reg;
  assign bus.tx_busy      = state != IDLE;
  assign bus.tx_done_tick = state == STOP && stop_end;
endmodule

// File: tb/tb_uart_tx_os.sv
// tb_uart_tx_os: randomized and directed checks of uart_tx_os against a tick-count frame model.
module tb_uart_tx_os;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FR0 = (9 + P) * 16 + 16;
  logic clk = 1'b0;
  logic reset_n;
  int n_chk = 0;
  int n_fail = 0;
  int mode[2];
  int tc[2] = '{0, 0};
  logic tk[2] = '{1'b0, 1'b0};
  logic st[2];
  logic [7:0] dn[2];
  logic o_tx[2], o_busy[2], o_done[2];
  logic act[2];
  int t[2];
  logic [7:0] w[2];
  uart_tx_os_if #(.DBIT(8)) b0 ();
  uart_tx_os_if #(.DBIT(8)) b1 ();
  assign b0.s_tick = tk[0];
  assign b0.tx_start = st[0];
  assign b0.din = dn[0];
  assign b1.s_tick = tk[1];
  assign b1.tx_start = st[1];
  assign b1.din = dn[1];
  assign o_tx[0] = b0.tx;
  assign o_busy[0] = b0.tx_busy;
  assign o_done[0] = b0.tx_done_tick;
  assign o_tx[1] = b1.tx;
  assign o_busy[1] = b1.tx_busy;
  assign o_done[1] = b1.tx_done_tick;
  uart_tx_os #(.DBIT(8), .SB_TICK(16)) dut0 (.clk(clk), .reset_n(reset_n), .bus(b0));
  uart_tx_os #(.DBIT(8), .SB_TICK(32)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));
  always #5 clk = ~clk;
  function automatic int fr(input int i);
    return (9 + P) * 16 + (i == 0 ? 16 : 32);
  endfunction
  // line level implied by how many ticks of the frame have elapsed
  function automatic logic exp_tx(input logic a, input int tt, input logic [7:0] ww);
    int k;
    k = tt / 16;
    if (!a) return 1'b1;
    if (k == 0) return 1'b0;
    if (k <= 8) return ww[k-1];
    if (P == 1 && k == 9) return ^ww;
    return 1'b1;
  endfunction
  task automatic check(input string nm, input logic [31:0] actual, input logic [31:0] expected);
    n_chk++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, actual, expected, $time);
    end
  endtask
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      tc[i] <= tc[i] + 1;
      tk[i] <= mode[i] == 0 ? 1'b0 : mode[i] == 255 ? ($urandom_range(0, 2) == 0) : (tc[i] % mode[i] == 0);
    end
  always @(posedge clk or negedge reset_n)
    if (!reset_n)
      for (int i = 0; i < 2; i++) begin
        act[i] <= 1'b0;
        t[i] <= 0;
        w[i] <= '0;
      end
    else
      for (int i = 0; i < 2; i++)
        if (!act[i]) begin
          if (st[i]) begin
            act[i] <= 1'b1;
            t[i] <= 0;
            w[i] <= dn[i];
          end
        end else if (tk[i]) begin
          if (t[i] == fr(i) - 1) act[i] <= 1'b0;
          else t[i] <= t[i] + 1;
        end
  always @(negedge clk)
    if (reset_n)
      for (int i = 0; i < 2; i++) begin
        check($sformatf("tx%0d", i), o_tx[i], exp_tx(act[i], t[i], w[i]));
        check($sformatf("busy%0d", i), o_busy[i], act[i]);
        check($sformatf("done%0d", i), o_done[i], act[i] && tk[i] && t[i] == fr(i) - 1);
      end
  task automatic accept(input int i, input logic [7:0] d);
    @(posedge clk);
    #1 st[i] = 1'b1;
    dn[i] = d;
    @(posedge clk);
    #1 st[i] = 1'b0;
  endtask
  task automatic wait_done(input int i, input int lim, output int c);
    for (c = 1; c <= lim; c++) begin
      @(negedge clk);
      if (o_done[i]) break;
    end
    check("done_seen", c <= lim, 1);
  endtask
  initial begin
    int dcount, dlast, c, first, run, fin, m;
    logic [10:0] pat;
    logic seen;
    pat = (P == 1) ? 11'b10101001010 : 11'b01101001010;
    mode[0] = 1;
    mode[1] = 7;
    st = '{1'b0, 1'b0};
    dn = '{8'h00, 8'h00};
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("rst_tx", o_tx[0], 1);
    check("rst_busy", o_busy[0], 0);
    check("rst_done", o_done[0], 0);
    check("rst_tx1", o_tx[1], 1);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    // basic frame: A5 with a tick every cycle
    accept(0, 8'hA5);
    dcount = 0;
    dlast = 0;
    for (int j = 1; j <= FR0; j++) begin
      @(negedge clk);
      if (j % 16 == 8) check($sformatf("a5_bit%0d", j / 16), o_tx[0], pat[j/16]);
      if (o_done[0]) begin
        dcount++;
        dlast = j;
      end
    end
    check("a5_done_count", dcount, 1);
    check("a5_done_cycle", dlast, P == 1 ? 176 : 160);
    // 07: parity bit (when present) is 1, otherwise that slot is the stop bit
    accept(0, 8'h07);
    dlast = 0;
    for (int j = 1; j <= FR0; j++) begin
      @(negedge clk);
      if (j == 9 * 16 + 8) check("07_bit9", o_tx[0], 1);
      if (j == 8 * 16 + 8) check("07_bit8", o_tx[0], 0);
      if (o_done[0]) dlast = j;
    end
    check("07_done_cycle", dlast, FR0);
    // request mid-frame is dropped
    accept(0, 8'h3C);
    dcount = 0;
    for (int j = 1; j <= FR0 + 40; j++) begin
      @(negedge clk);
      if (j == 50) begin
        st[0] = 1'b1;
        dn[0] = 8'hFF;
      end
      if (j == 51) st[0] = 1'b0;
      if (o_done[0]) dcount++;
    end
    check("ign_done_count", dcount, 1);
    check("ign_idle", o_busy[0], 0);
    // back-to-back with tx_start held high
    @(posedge clk);
    #1 st[0] = 1'b1;
    dn[0] = 8'h55;
    @(posedge clk);
    #1 dn[0] = 8'hAA;
    wait_done(0, 400, c);
    check("b2b_first_len", c, FR0);
    @(negedge clk);
    check("gap_busy", o_busy[0], 0);
    check("gap_tx", o_tx[0], 1);
    @(negedge clk);
    check("b2b_busy", o_busy[0], 1);
    check("b2b_start", o_tx[0], 0);
    @(posedge clk);
    #1 st[0] = 1'b0;
    wait_done(0, 400, c);
    check("b2b_second_len", c, FR0 - 1);
    // asynchronous reset in the middle of a data bit of 00
    accept(0, 8'h00);
    repeat (60) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_tx", o_tx[0], 1);
    check("mid_rst_busy", o_busy[0], 0);
    check("mid_rst_done", o_done[0], 0);
    repeat (3) @(negedge clk);
    check("mid_rst_hold", o_tx[0], 1);
    #1 reset_n = 1'b1;
    // sparse ticks (every 7 cycles) on the two-stop-bit instance
    accept(1, 8'h12);
    first = 0;
    run = 0;
    fin = 0;
    seen = 1'b0;
    for (int j = 1; j <= 3000 && !seen; j++) begin
      @(negedge clk);
      if (o_tx[1]) run++;
      else begin
        if (run > 0 && first == 0) first = run;
        run = 0;
      end
      if (o_done[1]) begin
        seen = 1'b1;
        fin = run;
      end
    end
    check("sparse_done_seen", seen, 1);
    check("sparse_bit_len", first, 112);
    check("sparse_stop_len", fin, 224);
    // randomized traffic, tick patterns and stalls
    for (int c2 = 0; c2 < 6000; c2++) begin
      @(posedge clk);
      #1;
      if (c2 % 300 == 0) begin
        m = $urandom_range(0, 3);
        mode[0] = m == 0 ? 1 : m == 1 ? 3 : m == 2 ? 255 : 0;
        m = $urandom_range(0, 2);
        mode[1] = m == 0 ? 1 : m == 1 ? 7 : 255;
      end
      st[0] = $urandom_range(0, 15) == 0;
      dn[0] = 8'($urandom);
      st[1] = $urandom_range(0, 63) == 0;
      dn[1] = 8'($urandom);
    end
    @(posedge clk);
    #1 st = '{1'b0, 1'b0};
    mode[0] = 1;
    mode[1] = 1;
    seen = 1'b0;
    for (int j = 0; j < 3000 && !seen; j++) begin
      @(negedge clk);
      seen = !o_busy[0] && !o_busy[1];
    end
    check("drain_idle", seen, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
